// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/decode/launch sequencer for the microcode control unit
// Optional watchdog on segment completion: define SEQ_WATCHDOG_EN.
module instr_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int RESET_PC       = 0,
  parameter int MIN_SEG_CYCLES = 1,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic              sos,
  input  logic              eos,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       retired
);

`ifdef SEQ_WATCHDOG_EN
  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_LAUNCH, ST_WAIT, ST_HALT, ST_FAULT
  } state_t;
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
`else
  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_LAUNCH, ST_WAIT, ST_HALT
  } state_t;
`endif

  localparam logic [5:0]        OP_HALT    = 6'h3F;
  localparam logic [3:0]        MIN_SEG    = 4'(MIN_SEG_CYCLES);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [5:0]        r_instr_op;
  logic [5:0]        r_instr_fn;
  logic [5:0]        r_opcode;
  logic [5:0]        r_funct;
  logic [31:0]       r_retired;
  logic [3:0]        r_cnt;
  logic              w_accept;
  logic              w_unused;

  // eos may still be high from the previous segment, so it is masked until the minimum dwell elapses
  assign w_accept = (r_state == ST_WAIT) && (r_cnt >= MIN_SEG) && eos;

`ifdef SEQ_WATCHDOG_EN
  logic [WDT_W-1:0] r_wdt;
  logic             w_wdt_expire;
  assign w_wdt_expire = (r_wdt == WDT_W'(WDT_CYCLES - 1));
  assign fault        = (r_state == ST_FAULT);
  assign w_unused     = ^{imem_rdata[25:6], pc_load_addr[1:0]};
`else
  assign fault    = 1'b0;
  assign w_unused = ^{imem_rdata[25:6], pc_load_addr[1:0], (WDT_CYCLES > 0)};
`endif

  // Handshake outputs decode straight from state so they fall with the async reset
  assign imem_req  = (r_state == ST_FETCH);
  assign sos       = (r_state == ST_LAUNCH);
  assign halted    = (r_state == ST_HALT);
  assign imem_addr = r_pc;
  assign opcode    = r_opcode;
  assign funct     = r_funct;
  assign retired   = r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH:  if (imem_ack) w_next = ST_DECODE;
      ST_DECODE: w_next = (r_instr_op == OP_HALT) ? ST_HALT : ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_accept) w_next = ST_FETCH;
`ifdef SEQ_WATCHDOG_EN
        else if (w_wdt_expire) w_next = ST_FAULT;
`endif
      end
      default:   w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC_C;
      r_instr_op <= 6'h00;
      r_instr_fn <= 6'h00;
      r_opcode   <= OP_HALT;
      r_funct    <= 6'h00;
      r_retired  <= 32'h0;
      r_cnt      <= 4'h0;
    end else begin
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_instr_op <= imem_rdata[31:26];
        r_instr_fn <= imem_rdata[5:0];
      end
      if (r_state == ST_DECODE) begin
        r_opcode <= r_instr_op;
        r_funct  <= r_instr_fn;
      end
      if (r_state == ST_LAUNCH)
        r_cnt <= 4'h0;
      else if ((r_state == ST_WAIT) && (r_cnt != 4'hF))
        r_cnt <= r_cnt + 4'h1;
      if (w_accept) begin
        r_retired <= r_retired + 32'h1;
        r_pc      <= pc_load ? {pc_load_addr[ADDR_W-1:2], 2'b00} : r_pc + ADDR_W'(4);
      end
`ifdef SEQ_WATCHDOG_EN
      if ((r_state == ST_WAIT) && (w_next == ST_FAULT))
        r_opcode <= OP_HALT;
`endif
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_wdt <= '0;
    else if (r_state == ST_LAUNCH) r_wdt <= '0;
    else if (r_state == ST_WAIT)   r_wdt <= r_wdt + WDT_W'(1);
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench for instr_sequencer
// Main instance uses MIN_SEG_CYCLES=1; a second instance sharing inputs uses MIN_SEG_CYCLES=3.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        eos;
  logic        pc_load;
  logic [31:0] pc_load_addr;

  logic        req_a, sos_a, halted_a, fault_a;
  logic [31:0] addr_a, retired_a;
  logic [5:0]  opcode_a, funct_a;
  logic        req_b, sos_b, halted_b, fault_b;
  logic [31:0] addr_b, retired_b;
  logic [5:0]  opcode_b, funct_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic bad;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(32), .RESET_PC(0), .MIN_SEG_CYCLES(1), .WDT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode_a), .funct(funct_a),
    .sos(sos_a), .eos(eos), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .halted(halted_a), .fault(fault_a), .retired(retired_a));

  instr_sequencer #(.ADDR_W(32), .RESET_PC(0), .MIN_SEG_CYCLES(3), .WDT_CYCLES(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode_b), .funct(funct_b),
    .sos(sos_b), .eos(eos), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .halted(halted_b), .fault(fault_b), .retired(retired_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C00_0000;
    eos = 1'b1; pc_load = 1'b0; pc_load_addr = 32'h0;
    #12;
    chk("rst_req", req_a, 0);
    chk("rst_sos", sos_a, 0);
    chk("rst_opcode", opcode_a, 6'h3F);
    chk("rst_funct", funct_a, 0);
    chk("rst_halted", halted_a, 0);
    chk("rst_fault", fault_a, 0);
    chk("rst_retired", retired_a, 0);
    chk("rst_addr", addr_a, 0);

    release_reset();
    step(); // 1: FETCH, same-cycle ack
    chk("c1_req", req_a, 1);
    chk("c1_addr", addr_a, 0);
    chk("c1_sos", sos_a, 0);
    step(); // 2: DECODE
    chk("c2_req_drop", req_a, 0);
    chk("c2_sos", sos_a, 0);
    step(); // 3: LAUNCH
    chk("c3_sos", sos_a, 1);
    chk("c3_opcode", opcode_a, 6'h23);
    chk("c3_funct", funct_a, 6'h00);
    step(); // 4: WAIT count 0
    chk("c4_sos", sos_a, 0);
    chk("c4_opcode", opcode_a, 6'h23);
    chk("c4_retired", retired_a, 0);
    step(); // 5: WAIT count 1, accepts
    chk("c5_retired", retired_a, 0);
    step(); // 6: FETCH next
    chk("c6_retired", retired_a, 1);
    chk("c6_req", req_a, 1);
    chk("c6_addr", addr_a, 4);
    chk("min3_c6_retired", retired_b, 0);
    imem_rdata = 32'h0000_0025;
    pc_load = 1'b1; pc_load_addr = 32'h0000_0103;
    step(); // 7
    chk("min3_c7_retired", retired_b, 0);
    step(); // 8: LAUNCH
    chk("min3_c8_retired", retired_b, 1);
    chk("c8_opcode", opcode_a, 6'h00);
    chk("c8_funct", funct_a, 6'h25);
    chk("c8_sos", sos_a, 1);
    step(); // 9
    step(); // 10: acceptance cycle, redirect withdrawn
    pc_load = 1'b0;
    step(); // 11
    chk("c11_addr_seq", addr_a, 8);
    chk("c11_retired", retired_a, 2);
    pc_load = 1'b1; pc_load_addr = 32'h0000_0103;
    for (int i = 0; i < 5; i++) step(); // 16
    chk("c16_addr_redirect", addr_a, 32'h100);
    chk("c16_retired", retired_a, 3);
    pc_load = 1'b0;
    imem_rdata = 32'hFC00_0000;
    step(); // 17: DECODE
    chk("c17_sos", sos_a, 0);
    step(); // 18: HALT
    chk("halt_halted", halted_a, 1);
    chk("halt_opcode", opcode_a, 6'h3F);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req_a || sos_a || !halted_a) bad = 1'b1;
    end
    chk("halt_absorb", bad, 0);
    chk("halt_retired", retired_a, 3);

    // Reset during WAIT with pc=0x40
    rst_n = 1'b0;
    imem_rdata = 32'h8C00_0000; eos = 1'b1; pc_load = 1'b1; pc_load_addr = 32'h40;
    release_reset();
    for (int i = 0; i < 6; i++) step(); // 6
    chk("r_c6_addr", addr_a, 32'h40);
    eos = 1'b0; pc_load = 1'b0;
    for (int i = 0; i < 4; i++) step(); // 10: WAIT
    chk("r_wait_sos", sos_a, 0);
    chk("r_wait_req", req_a, 0);
    chk("r_wait_opcode", opcode_a, 6'h23);
    chk("r_wait_retired", retired_a, 1);
    rst_n = 1'b0;
    #1;
    chk("async_sos", sos_a, 0);
    chk("async_req", req_a, 0);
    chk("async_opcode", opcode_a, 6'h3F);
    chk("async_retired", retired_a, 0);
    chk("async_addr", addr_a, 0);
    release_reset();
    imem_ack = 1'b0;
    step(); // 1
    chk("post_rst_req", req_a, 1);
    chk("post_rst_addr", addr_a, 0);
    chk("post_rst_retired", retired_a, 0);
    step(); // 2: still fetching, no ack
    chk("fetch_hold_req", req_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_fetch_req", req_a, 0);

    // Segment that never ends
    imem_ack = 1'b1; eos = 1'b0;
    release_reset();
    for (int i = 0; i < 19; i++) step(); // 19: last WAIT cycle before expiry
    chk("wdt_c19_fault", fault_a, 0);
    chk("wdt_c19_retired", retired_a, 0);
    step(); // 20
`ifdef SEQ_WATCHDOG_EN
    chk("wdt_fault", fault_a, 1);
    chk("wdt_opcode", opcode_a, 6'h3F);
`else
    chk("wdt_fault_off", fault_a, 0);
    chk("wdt_opcode_held", opcode_a, 6'h23);
`endif
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (req_a || sos_a) bad = 1'b1;
    end
    chk("wdt_no_fetch", bad, 0);
    chk("wdt_retired", retired_a, 0);
    chk("wdt_addr", addr_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Sits directly upstream of the microcode control unit and drives its opcode, sos and eos handshake.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake, then decodes opcode [31:26] and funct [5:0].
- Launches one microcode segment per instruction and waits for end-of-segment.
- Then advances the PC, sequentially or by a datapath-supplied redirect. Halts on opcode 6'h3F.

Parameters:
- ADDR_W, 32, width of PC and imem_addr.
- RESET_PC, 0, PC value loaded at reset (word aligned).
- MIN_SEG_CYCLES, 1, cycles after sos falls before eos is honoured (range 1..15).
- WDT_CYCLES, 1024, watchdog limit in cycles. Used only with SEQ_WATCHDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- opcode  out  6  opcode presented to microcode unit.
- funct  out  6  funct field of current instruction.
- sos  out  1  start-of-segment pulse to microcode unit.
- eos  in  1  end-of-segment level from microcode unit.
- pc_load  in  1  redirect request, sampled at eos acceptance.
- pc_load_addr  in  ADDR_W  redirect target.
- halted  out  1  halt opcode reached.
- fault  out  1  watchdog fault (0 without the optional feature).
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=RESET_ST, pc=RESET_PC.
  - imem_req=0, sos=0, opcode=6'h3F (keeps microcode frozen), funct=0.
  - halted=0, fault=0, retired=0, wait counter=0.
- State RESET_ST: one cycle, then FETCH. Gives one clean edge after rst_n rises.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: latch imem_rdata into instr and go to DECODE. Same-cycle ack is allowed.
  - imem_req drops the cycle after ack.
- State DECODE:
  - opcode<=instr[31:26], funct<=instr[5:0].
  - If instr[31:26]==6'h3F, go to HALT; otherwise go to LAUNCH.
- State LAUNCH: sos=1 for exactly one cycle, opcode stable. Then WAIT.
- State WAIT:
  - sos=0, opcode held stable throughout.
  - The counter counts from 0. eos is ignored while count < MIN_SEG_CYCLES, because eos may still be high from the previous segment.
  - Once count >= MIN_SEG_CYCLES and eos=1, the instruction retires:
    - retired++ (wraps at 2^32).
    - pc<=pc_load ? {pc_load_addr[ADDR_W-1:2],2'b00} : pc+4. Wraps modulo 2^ADDR_W.
    - Go to FETCH.
  - The counter saturates and resets on entry to WAIT.
- State HALT:
  - halted=1, opcode=6'h3F, sos=0, imem_req=0.
  - Absorbing; exit only via rst_n.
- Latency: minimum instruction period with same-cycle ack is FETCH(1)+DECODE(1)+LAUNCH(1)+WAIT(MIN_SEG_CYCLES+1) = 5 cycles at default.
- pc_load is sampled only in the eos-acceptance cycle and ignored elsewhere.
- Reset mid-fetch or mid-segment: all state is abandoned immediately. imem_req and sos drop asynchronously. Any pending ack is discarded.
- imem_ack asserted outside FETCH is ignored.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT. If it reaches WDT_CYCLES without eos acceptance, go to FAULT.
  - FAULT sets fault=1 and opcode=6'h3F, with no sos and no fetch. Absorbing until reset.
  - retired and pc are not updated.
- Not defined:
  - WAIT waits indefinitely and fault is tied 0.
  - No FAULT state and no counter logic are synthesised.

Test Plan:
- Reset then release, imem acks word 0x8C000000 (LW) at addr 0 in the same cycle → opcode=6'h23, one-cycle sos at cycle 3. Hold eos=1 throughout → retire at cycle 5, next fetch addr 4, retired=1.
- eos stuck high from the previous segment, MIN_SEG_CYCLES=3 → no retire before 3 WAIT cycles, retire on the 4th.
- Retire with pc_load=1, pc_load_addr=0x103 → next imem_addr=0x100. Redirect pulse outside acceptance → pc=pc+4.
- Fetch 0xFC000000 → halted=1, opcode=6'h3F, no sos. imem_req stays 0 for 100 cycles.
- rst_n low during WAIT with pc=0x40 → immediate sos=0, imem_req=0, opcode=6'h3F. After release, first fetch addr=RESET_PC and retired=0.
- SEQ_WATCHDOG_EN, WDT_CYCLES=16, eos held 0 → fault=1 after 16 WAIT cycles, no further fetches. Without the macro → waits, fault=0.
